filter_loader: RTL and testbench

FILTER_LOADER -- requirements
Module: filter_loader

---
 rtl/filter_loader.sv | 113 +++++++++++
 tb/tb_filter_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_loader.sv
// Fetches a 4-row x 32-bit filter from word memory into the filter buffer,
// one outstanding read at a time, then flags the buffer as readable.
//
// state | meaning
// IDLE  | waiting for start; buf_re reflects the last completed load
// REQ   | read request for the current row is presented until granted
// WAIT  | request granted, waiting for the returned word
module filter_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_we,
    output logic [1:0]        buf_i,
    output logic [31:0]       buf_data,
    output logic              buf_re,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        row;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_valid) begin
                    capture   = 1'b1;
                    state_nxt = (row == 2'd3) ? IDLE : REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address is only driven while requesting; wraps modulo 2^ADDR_W.
    assign mem_addr = mem_rd ? (base + ADDR_W'(row)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            row      <= 2'd0;
            buf_we   <= 1'b0;
            buf_i    <= 2'd0;
            buf_data <= 32'd0;
            buf_re   <= 1'b0;
            done     <= 1'b0;
        end else begin
            buf_we <= capture;
            done   <= capture && (row == 2'd3);
            // A new load invalidates the buffer even if it lands in the done cycle.
            if (accept) begin
                base   <= base_addr;
                row    <= 2'd0;
                buf_re <= 1'b0;
            end else if (done) begin
                buf_re <= 1'b1;
            end
            if (capture) begin
                buf_data <= mem_rdata;
                buf_i    <= row;
                row      <= row + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_filter_loader.sv
// Randomized and directed bench for filter_loader: a memory responder with
// configurable grant/response delays feeds a queue-based load model.
module tb_filter_loader;
    localparam int AW = 16;

    typedef struct {
        logic [1:0]  row;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          buf_we;
    logic [1:0]    buf_i;
    logic [31:0]   buf_data;
    logic          buf_re;
    logic          busy;
    logic          done;

    filter_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .buf_we(buf_we), .buf_i(buf_i), .buf_data(buf_data),
        .buf_re(buf_re), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    // load model
    bit            model_active = 0;
    bit            re_model = 0;
    bit            last_ed = 0;
    bit            prev_re = 0;
    logic [AW-1:0] exp_addr[$];
    wr_t           exp_wr[$];
    int            we_log[$];
    int            rd_log[$];
    int            done_log[$];
    int            re_rise_log[$];

    // memory responder
    bit            pending = 0;
    bit            in_req = 0;
    bit            spur_en = 0;
    int            gstall = 0;
    int            vwait = 0;
    int            mode = 0;
    logic [AW-1:0] paddr = '0;
    int            stall_tab[4];
    int            vdel_tab[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        case (a)
            16'h0010: return 32'h01020304;
            16'h0011: return 32'h05060708;
            16'h0012: return 32'h090A0B0C;
            16'h0013: return 32'h0D0E0F10;
            default:  return {a, ~a} ^ 32'h5A3C96E1;
        endcase
    endfunction

    function automatic int pick_stall(input int k);
        if (mode == 0) return 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return stall_tab[k];
    endfunction

    function automatic int pick_vdel(input int k);
        if (mode == 0) return 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return vdel_tab[k];
    endfunction

    task automatic monitor(output bit ed);
        wr_t e;
        bit  rd_ok;
        ed = 0;
        if (buf_we) begin
            we_log.push_back(cyc);
            if (exp_wr.size() == 0) begin
                chk("unexpected_we", buf_we, 1'b0);
            end else begin
                e = exp_wr.pop_front();
                chk("buf_i", buf_i, e.row);
                chk("buf_data", buf_data, e.data);
                if (e.row == 2'd3) begin
                    ed = 1;
                    model_active = 0;
                end
            end
        end
        chk("done", done, ed);
        if (done) done_log.push_back(cyc);
        chk("busy", busy, model_active);
        chk("buf_re", buf_re, re_model);
        if (buf_re && !prev_re) re_rise_log.push_back(cyc);
        prev_re = buf_re;
        rd_ok = model_active && !pending && (exp_addr.size() != 0);
        if (mem_rd) begin
            rd_log.push_back(cyc);
            if (!rd_ok) chk("unexpected_rd", mem_rd, 1'b0);
            else        chk("mem_addr", mem_addr, exp_addr[0]);
        end
    endtask

    task automatic respond();
        int k;
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        if (pending) begin
            if (vwait > 0) begin
                vwait--;
            end else begin
                mem_valid = 1'b1;
                mem_rdata = mem_word(paddr);
                pending   = 0;
            end
        end else begin
            if (spur_en && $urandom_range(0, 3) == 0) mem_valid = 1'b1;
            if (mem_rd && exp_addr.size() != 0) begin
                k = 4 - exp_addr.size();
                if (!in_req) begin
                    in_req = 1;
                    gstall = pick_stall(k);
                end
                if (gstall > 0) begin
                    gstall--;
                end else begin
                    mem_gnt = 1'b1;
                    in_req  = 0;
                    pending = 1;
                    paddr   = mem_addr;
                    vwait   = pick_vdel(k);
                    void'(exp_addr.pop_front());
                end
            end
        end
    endtask

    // Drive start for the current cycle, then advance one clock and check it.
    task automatic cycle(input bit st, input logic [AW-1:0] ba);
        logic [AW-1:0] a;
        bit ed;
        start     = st;
        base_addr = ba;
        if (st && rst_n && !model_active) begin
            model_active = 1;
            re_model     = 0;
            for (int k = 0; k < 4; k++) begin
                a = ba + AW'(k);
                exp_addr.push_back(a);
                exp_wr.push_back('{2'(k), mem_word(a)});
            end
        end else if (last_ed) begin
            re_model = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        monitor(ed);
        last_ed = ed;
        respond();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (model_active && n < bound) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("load_completes", model_active, 1'b0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_buf_i", buf_i, 0);
        chk("rst_buf_data", buf_data, 0);
        chk("rst_buf_re", buf_re, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        model_active = 0;
        re_model     = 0;
        last_ed      = 0;
        prev_re      = 0;
        in_req       = 0;
        exp_addr.delete();
        exp_wr.delete();
    endtask

    task automatic clear_logs();
        we_log.delete();
        rd_log.delete();
        done_log.delete();
        re_rise_log.delete();
    endtask

    initial begin
        int s;
        #1;
        assert_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // zero-wait load right after reset release, with cycle-exact latency
        mode = 0;
        clear_logs();
        s = cyc;
        cycle(1'b1, 16'h0010);
        wait_idle(40);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        chk("rd_count", rd_log.size(), 4);
        chk("we_count", we_log.size(), 4);
        if (rd_log.size() == 4 && we_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("lat_rd", rd_log[i] - s, 1 + 2 * i);
                chk("lat_we", we_log[i] - s, 3 + 2 * i);
            end
        end
        chk("done_count", done_log.size(), 1);
        if (done_log.size() == 1) chk("lat_done", done_log[0] - s, 9);
        chk("re_rise_count", re_rise_log.size(), 1);
        if (re_rise_log.size() == 1) chk("lat_re", re_rise_log[0] - s, 10);

        // grant stall on row 1, delayed response on row 2
        mode = 2;
        stall_tab = '{0, 3, 0, 0};
        vdel_tab  = '{0, 0, 2, 0};
        clear_logs();
        cycle(1'b1, 16'h0010);
        wait_idle(60);
        cycle(1'b0, '0);
        chk("stall_we_count", we_log.size(), 4);
        chk("stall_rd_cycles", rd_log.size(), 7);
        chk("stall_done_count", done_log.size(), 1);

        // start pulses during a load are ignored
        mode = 0;
        clear_logs();
        cycle(1'b1, 16'h0040);
        cycle(1'b0, '0);
        cycle(1'b1, 16'h0099);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        cycle(1'b1, 16'h0077);
        wait_idle(40);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        chk("ignored_start_we_count", we_log.size(), 4);

        // address wrap
        cycle(1'b1, 16'hFFFE);
        wait_idle(40);
        cycle(1'b0, '0);

        // start in the done cycle chains a new load with buf_re held low
        clear_logs();
        cycle(1'b1, 16'h0020);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0);
        cycle(1'b1, 16'h0030);
        chk("chain_done_seen", done_log.size(), 1);
        wait_idle(40);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        chk("chain_we_count", we_log.size(), 8);
        chk("chain_re_rise", re_rise_log.size(), 1);

        // reset while waiting on row 2; the late response must be ignored
        mode = 2;
        stall_tab = '{0, 0, 0, 0};
        vdel_tab  = '{0, 0, 6, 0};
        clear_logs();
        cycle(1'b1, 16'h0100);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0);
        #1;
        assert_reset();
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20 && pending; i++) cycle(1'b0, '0);
        chk("stale_resp_delivered", pending, 1'b0);
        cycle(1'b0, '0);
        chk("abandoned_we_count", we_log.size(), 2);
        chk("abandoned_done_count", done_log.size(), 0);
        mode = 0;
        cycle(1'b1, 16'h0010);
        wait_idle(40);
        cycle(1'b0, '0);
        chk("after_rst_re", buf_re, 1'b1);

        // randomized traffic: random delays, spurious responses, random starts
        mode    = 1;
        spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) == 0, AW'($urandom));
        end
        spur_en = 0;
        wait_idle(100);
        cycle(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
